stg_2_id_hazard: RTL and testbench
==================================

Name: stg_2_id_hazard

Overview:
Parametrised second-generation instruction-decode stage. It decodes the ID-stage instruction using the existing instructionDecoder helper and registers the results into the ID/EX pipeline register, adding a valid bit. It tracks in-flight destination registers in a scoreboard and, depending on mode, either stalls IF on read-after-write hazards or emits forwarding selects for EX. It supports a flush input and counts stall cycles for performance monitoring.

Parameters:
INSTR_W, 32, instruction width
REG_ADDR_W, 5, register address width
VALUE_W, 32, immediate/value width
ALU_OP_W, 4, ALU opcode width
HAZ_DEPTH, 3, in-flight stages tracked after ID (EX..WB inclusive), min 1
FORWARD_EN, 0, 0 = stall on hazard; 1 = never stall, emit forwarding selects
FWD_W, $clog2(HAZ_DEPTH+1), forwarding select width
STALL_CNT_W, 16, stall counter width

Ports:
sys_clock  in  1  clock
reset_n  in  1  asynchronous, active-low reset
r_id_valid  in  1  r_id_instr holds a real instruction
r_id_instr  in  INSTR_W  instruction in ID
i_flush  in  1  kill the instruction currently in ID
o_id_ready  out  1  ID accepts/consumes r_id_instr this cycle; 0 = IF must hold
s_id_rs1, s_id_rs2  out  REG_ADDR_W  combinational source addresses to the register file
r_ex_valid  out  1  EX holds a real instruction
r_ex_aluop  out  ALU_OP_W  registered ALU op
r_ex_rd  out  REG_ADDR_W  registered destination
r_ex_imm  out  VALUE_W  registered immediate
r_ex_instr  out  INSTR_W  registered raw instruction
r_ex_RegWrite, r_ex_PrintValue  out  1  registered control; forced 0 on bubbles
r_ex_fwd_sel1, r_ex_fwd_sel2  out  FWD_W  0 = register file, k = result of instruction k stages ahead; always 0 when FORWARD_EN=0
o_stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, active-low): all r_ex_* = 0, scoreboard cleared, o_stall_cnt = 0. o_id_ready = 1 during reset.
- Scoreboard: HAZ_DEPTH entries {v, rd}. Entry 0 = instruction in EX; entry HAZ_DEPTH-1 = instruction in WB. Shifts every cycle (downstream never stalls).
  - entry0 <= {issue & RegWrite & (rd != 0), rd}
  - entry[k] <= entry[k-1]
  - The oldest entry is discarded.
- Match: rsX matches entry k if v[k] and rd[k] == rsX and rsX != 0. Both rs1 and rs2 are always treated as read (conservative). The WB entry counts as a hazard because the register file is not write-through.
- hazard = r_id_valid & (any rs1 match | any rs2 match) & (FORWARD_EN == 0).
- Priority: reset > flush > hazard > issue.
  - Flush: o_id_ready = 1; EX gets a bubble; the ID instruction is dropped; o_stall_cnt does not increment; the scoreboard still shifts.
  - Hazard (no flush): o_id_ready = 0; EX gets a bubble; o_stall_cnt += 1, saturating at all-ones.
  - Issue (r_id_valid, no flush, no hazard): o_id_ready = 1; the decoded fields are registered with r_ex_valid = 1.
  - r_id_valid = 0: EX gets a bubble; o_id_ready = 1.
- Bubble: r_ex_valid = 0, r_ex_RegWrite = 0, r_ex_PrintValue = 0, fwd_sel = 0. Other r_ex_* fields also clear to 0.
- Forwarding (FORWARD_EN=1): r_ex_fwd_selX <= 1 + index of the youngest (lowest k) matching entry, else 0. Registered with the instruction.
- Latency: ID to EX is 1 cycle. o_id_ready and s_id_rs* are combinational from the current state and inputs.
- Stall duration (FORWARD_EN=0) for a consumer immediately behind its producer is HAZ_DEPTH cycles.

Test Plan:
- FORWARD_EN=0, HAZ_DEPTH=3: A (rd=x3, RegWrite=1) then B (rs1=x3) back-to-back -> o_id_ready low 3 cycles; 3 bubbles in EX; B reaches EX 4 cycles after A; o_stall_cnt=3.
- Same pair with A's rd=x0, or A RegWrite=0 -> no stall; B follows A in EX next cycle; o_stall_cnt=0.
- FORWARD_EN=1, HAZ_DEPTH=3: A (rd=x5); C (rd=x6); B (rs1=x5, rs2=x6) -> no stall; in EX, B has r_ex_fwd_sel1=2, r_ex_fwd_sel2=1.
- FORWARD_EN=0: during the 2nd stall cycle of scenario 1, assert i_flush one cycle -> o_id_ready=1 that cycle; bubble in EX; o_stall_cnt stays 1; A's scoreboard entry keeps shifting out.
- Reset asserted mid-stall -> all r_ex_* 0, o_stall_cnt 0, scoreboard empty; after release, an instruction reading x3 issues without stall.
- STALL_CNT_W=2 with a repeated hazard stream -> o_stall_cnt saturates at 3 and holds.

Source files
------------

// File: rtl/stg_2_id_hazard.sv
// Instruction decoder and second-generation ID stage: decodes the ID instruction into the
// ID/EX register, tracks in-flight destinations and either stalls on RAW hazards or selects forwarding.

// Decode map: OP (0110011), OP-IMM (0010011), LOAD (0000011) and LUI (0110111) write rd;
// STORE (0100011) and PRINT (0001011) do not. rd reads as 0 for non-writing instructions.
module instruction_decoder #(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int VALUE_W    = 32,
  parameter int ALU_OP_W   = 4
) (
  input  logic [INSTR_W-1:0]    instr_i,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [ALU_OP_W-1:0]   aluop_o,
  output logic [VALUE_W-1:0]    imm_o,
  output logic                  reg_write_o,
  output logic                  print_value_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_PRINT  = 7'b0001011;
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [3:0]  aluop4;
  logic [31:0] imm32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign alt    = instr_i[30];
  assign rs1_o  = instr_i[15 +: REG_ADDR_W];
  assign rs2_o  = instr_i[20 +: REG_ADDR_W];

  always_comb begin
    rd_o          = '0;
    aluop4        = ALU_ADD;
    imm32         = '0;
    reg_write_o   = 1'b0;
    print_value_o = 1'b0;
    case (opcode)
      OPC_OP: begin
        reg_write_o = 1'b1;
        rd_o        = instr_i[7 +: REG_ADDR_W];
        aluop4      = {alt, funct3};
      end
      OPC_OP_IMM: begin
        // Only shift-right uses bit 30 as a function bit; elsewhere it is immediate data.
        reg_write_o = 1'b1;
        rd_o        = instr_i[7 +: REG_ADDR_W];
        aluop4      = {(funct3 == 3'b101) & alt, funct3};
        imm32       = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_LOAD: begin
        reg_write_o = 1'b1;
        rd_o        = instr_i[7 +: REG_ADDR_W];
        imm32       = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_LUI: begin
        reg_write_o = 1'b1;
        rd_o        = instr_i[7 +: REG_ADDR_W];
        aluop4      = ALU_PASS_B;
        imm32       = {instr_i[31:12], 12'b0};
      end
      OPC_STORE: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_PRINT: begin
        print_value_o = 1'b1;
      end
      default: begin
        reg_write_o = 1'b0;
      end
    endcase
  end

  assign aluop_o = ALU_OP_W'(aluop4);
  assign imm_o   = VALUE_W'(imm32);

endmodule

module stg_2_id_hazard #(
  parameter int INSTR_W     = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int VALUE_W     = 32,
  parameter int ALU_OP_W    = 4,
  parameter int HAZ_DEPTH   = 3,
  parameter int FORWARD_EN  = 0,
  parameter int FWD_W       = $clog2(HAZ_DEPTH + 1),
  parameter int STALL_CNT_W = 16
) (
  input  logic                   sys_clock,
  input  logic                   reset_n,
  input  logic                   r_id_valid,
  input  logic [INSTR_W-1:0]     r_id_instr,
  input  logic                   i_flush,
  output logic                   o_id_ready,
  output logic [REG_ADDR_W-1:0]  s_id_rs1,
  output logic [REG_ADDR_W-1:0]  s_id_rs2,
  output logic                   r_ex_valid,
  output logic [ALU_OP_W-1:0]    r_ex_aluop,
  output logic [REG_ADDR_W-1:0]  r_ex_rd,
  output logic [VALUE_W-1:0]     r_ex_imm,
  output logic [INSTR_W-1:0]     r_ex_instr,
  output logic                   r_ex_RegWrite,
  output logic                   r_ex_PrintValue,
  output logic [FWD_W-1:0]       r_ex_fwd_sel1,
  output logic [FWD_W-1:0]       r_ex_fwd_sel2,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  localparam logic STALL_MODE = (FORWARD_EN == 0);

  logic [REG_ADDR_W-1:0] dec_rd;
  logic [ALU_OP_W-1:0]   dec_aluop;
  logic [VALUE_W-1:0]    dec_imm;
  logic                  dec_reg_write;
  logic                  dec_print_value;

  instruction_decoder #(
    .INSTR_W    (INSTR_W),
    .REG_ADDR_W (REG_ADDR_W),
    .VALUE_W    (VALUE_W),
    .ALU_OP_W   (ALU_OP_W)
  ) u_decoder (
    .instr_i       (r_id_instr),
    .rs1_o         (s_id_rs1),
    .rs2_o         (s_id_rs2),
    .rd_o          (dec_rd),
    .aluop_o       (dec_aluop),
    .imm_o         (dec_imm),
    .reg_write_o   (dec_reg_write),
    .print_value_o (dec_print_value)
  );

  // Scoreboard: entry 0 is the instruction in EX, entry HAZ_DEPTH-1 the one in WB.
  logic [HAZ_DEPTH-1:0]                 sb_v_q, sb_v_d;
  logic [HAZ_DEPTH-1:0][REG_ADDR_W-1:0] sb_rd_q, sb_rd_d;

  logic                   ex_valid_q, ex_valid_d;
  logic [ALU_OP_W-1:0]    ex_aluop_q, ex_aluop_d;
  logic [REG_ADDR_W-1:0]  ex_rd_q, ex_rd_d;
  logic [VALUE_W-1:0]     ex_imm_q, ex_imm_d;
  logic [INSTR_W-1:0]     ex_instr_q, ex_instr_d;
  logic                   ex_reg_write_q, ex_reg_write_d;
  logic                   ex_print_value_q, ex_print_value_d;
  logic [FWD_W-1:0]       ex_fwd_sel1_q, ex_fwd_sel1_d;
  logic [FWD_W-1:0]       ex_fwd_sel2_q, ex_fwd_sel2_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             match1, match2;
  logic [FWD_W-1:0] sel1, sel2;
  logic             hazard, issue, stall_inc;

  // Walk oldest to youngest so the youngest matching producer wins the select.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    sel1   = '0;
    sel2   = '0;
    for (int k = HAZ_DEPTH - 1; k >= 0; k--) begin
      if (sb_v_q[k] && (sb_rd_q[k] == s_id_rs1) && (s_id_rs1 != '0)) begin
        match1 = 1'b1;
        sel1   = FWD_W'(k + 1);
      end
      if (sb_v_q[k] && (sb_rd_q[k] == s_id_rs2) && (s_id_rs2 != '0)) begin
        match2 = 1'b1;
        sel2   = FWD_W'(k + 1);
      end
    end
  end

  assign hazard     = r_id_valid & (match1 | match2) & STALL_MODE;
  assign issue      = r_id_valid & ~i_flush & ~hazard;
  assign stall_inc  = hazard & ~i_flush;
  assign o_id_ready = ~reset_n | i_flush | ~hazard;

  always_comb begin
    sb_v_d     = '0;
    sb_rd_d    = '0;
    sb_v_d[0]  = issue & dec_reg_write & (dec_rd != '0);
    sb_rd_d[0] = dec_rd;
    for (int k = 1; k < HAZ_DEPTH; k++) begin
      sb_v_d[k]  = sb_v_q[k-1];
      sb_rd_d[k] = sb_rd_q[k-1];
    end
  end

  always_comb begin
    ex_valid_d       = issue;
    ex_aluop_d       = issue ? dec_aluop : '0;
    ex_rd_d          = issue ? dec_rd : '0;
    ex_imm_d         = issue ? dec_imm : '0;
    ex_instr_d       = issue ? r_id_instr : '0;
    ex_reg_write_d   = issue & dec_reg_write;
    ex_print_value_d = issue & dec_print_value;
    ex_fwd_sel1_d    = (issue && !STALL_MODE) ? sel1 : '0;
    ex_fwd_sel2_d    = (issue && !STALL_MODE) ? sel2 : '0;
    stall_cnt_d      = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_v_q           <= '0;
      sb_rd_q          <= '0;
      ex_valid_q       <= 1'b0;
      ex_aluop_q       <= '0;
      ex_rd_q          <= '0;
      ex_imm_q         <= '0;
      ex_instr_q       <= '0;
      ex_reg_write_q   <= 1'b0;
      ex_print_value_q <= 1'b0;
      ex_fwd_sel1_q    <= '0;
      ex_fwd_sel2_q    <= '0;
      stall_cnt_q      <= '0;
    end else begin
      sb_v_q           <= sb_v_d;
      sb_rd_q          <= sb_rd_d;
      ex_valid_q       <= ex_valid_d;
      ex_aluop_q       <= ex_aluop_d;
      ex_rd_q          <= ex_rd_d;
      ex_imm_q         <= ex_imm_d;
      ex_instr_q       <= ex_instr_d;
      ex_reg_write_q   <= ex_reg_write_d;
      ex_print_value_q <= ex_print_value_d;
      ex_fwd_sel1_q    <= ex_fwd_sel1_d;
      ex_fwd_sel2_q    <= ex_fwd_sel2_d;
      stall_cnt_q      <= stall_cnt_d;
    end
  end

  assign r_ex_valid      = ex_valid_q;
  assign r_ex_aluop      = ex_aluop_q;
  assign r_ex_rd         = ex_rd_q;
  assign r_ex_imm        = ex_imm_q;
  assign r_ex_instr      = ex_instr_q;
  assign r_ex_RegWrite   = ex_reg_write_q;
  assign r_ex_PrintValue = ex_print_value_q;
  assign r_ex_fwd_sel1   = ex_fwd_sel1_q;
  assign r_ex_fwd_sel2   = ex_fwd_sel2_q;
  assign o_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_stg_2_id_hazard.sv
// Directed bench for stg_2_id_hazard: stall mode, forwarding mode and a 2-bit stall counter
// instance share one input stream; each scenario task checks the instance it targets.
module tb_stg_2_id_hazard;

  logic        sys_clock;
  logic        reset_n;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic        i_flush;

  int total = 0;
  int bad   = 0;

  // stall-mode instance (defaults)
  logic a_ready, a_ex_valid, a_ex_rw, a_ex_pv;
  logic [4:0] a_rs1, a_rs2, a_ex_rd;
  logic [3:0] a_ex_aluop;
  logic [31:0] a_ex_imm, a_ex_instr;
  logic [1:0] a_sel1, a_sel2;
  logic [15:0] a_cnt;
  // forwarding instance
  logic f_ready, f_ex_valid, f_ex_rw, f_ex_pv;
  logic [4:0] f_rs1, f_rs2, f_ex_rd;
  logic [3:0] f_ex_aluop;
  logic [31:0] f_ex_imm, f_ex_instr;
  logic [1:0] f_sel1, f_sel2;
  logic [15:0] f_cnt;
  // 2-bit stall counter instance
  logic s_ready, s_ex_valid, s_ex_rw, s_ex_pv;
  logic [4:0] s_rs1, s_rs2, s_ex_rd;
  logic [3:0] s_ex_aluop;
  logic [31:0] s_ex_imm, s_ex_instr;
  logic [1:0] s_sel1, s_sel2;
  logic [1:0] s_cnt;

  stg_2_id_hazard u_dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .r_id_valid(r_id_valid), .r_id_instr(r_id_instr),
    .i_flush(i_flush), .o_id_ready(a_ready), .s_id_rs1(a_rs1), .s_id_rs2(a_rs2),
    .r_ex_valid(a_ex_valid), .r_ex_aluop(a_ex_aluop), .r_ex_rd(a_ex_rd), .r_ex_imm(a_ex_imm),
    .r_ex_instr(a_ex_instr), .r_ex_RegWrite(a_ex_rw), .r_ex_PrintValue(a_ex_pv),
    .r_ex_fwd_sel1(a_sel1), .r_ex_fwd_sel2(a_sel2), .o_stall_cnt(a_cnt)
  );

  stg_2_id_hazard #(.FORWARD_EN(1)) u_fwd (
    .sys_clock(sys_clock), .reset_n(reset_n), .r_id_valid(r_id_valid), .r_id_instr(r_id_instr),
    .i_flush(i_flush), .o_id_ready(f_ready), .s_id_rs1(f_rs1), .s_id_rs2(f_rs2),
    .r_ex_valid(f_ex_valid), .r_ex_aluop(f_ex_aluop), .r_ex_rd(f_ex_rd), .r_ex_imm(f_ex_imm),
    .r_ex_instr(f_ex_instr), .r_ex_RegWrite(f_ex_rw), .r_ex_PrintValue(f_ex_pv),
    .r_ex_fwd_sel1(f_sel1), .r_ex_fwd_sel2(f_sel2), .o_stall_cnt(f_cnt)
  );

  stg_2_id_hazard #(.STALL_CNT_W(2)) u_sat (
    .sys_clock(sys_clock), .reset_n(reset_n), .r_id_valid(r_id_valid), .r_id_instr(r_id_instr),
    .i_flush(i_flush), .o_id_ready(s_ready), .s_id_rs1(s_rs1), .s_id_rs2(s_rs2),
    .r_ex_valid(s_ex_valid), .r_ex_aluop(s_ex_aluop), .r_ex_rd(s_ex_rd), .r_ex_imm(s_ex_imm),
    .r_ex_instr(s_ex_instr), .r_ex_RegWrite(s_ex_rw), .r_ex_PrintValue(s_ex_pv),
    .r_ex_fwd_sel1(s_sel1), .r_ex_fwd_sel2(s_sel2), .o_stall_cnt(s_cnt)
  );

  // clock / reset
  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  // instruction encoders
  function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm, input logic [2:0] f3);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3, input logic alt);
    return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] mk_p(input logic [4:0] rs1);
    return {12'b0, rs1, 3'b000, 5'b0, 7'b0001011};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
    r_id_valid = v;
    r_id_instr = ins;
    i_flush    = fl;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, mk_i(5'd3, 5'd0, 12'd1, 3'd0), 1'b0);
    reset_n = 1'b0;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", a_ready); end
    total++; if (a_ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0h exp=0", a_ex_valid); end
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    tick();
    tick();
    total++; if (a_ex_instr !== 32'h0) begin bad++; $display("FAIL reset_hold_instr got=%0h exp=0", a_ex_instr); end
    total++; if (a_ex_rw !== 1'b0 || a_ex_rd !== 5'd0) begin bad++; $display("FAIL reset_hold_rw_rd got=%0h/%0d exp=0/0", a_ex_rw, a_ex_rd); end
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_decode();
    logic [31:0] ins;
    do_reset();
    ins = mk_i(5'd1, 5'd2, 12'hFFB, 3'd0);
    drive(1'b1, ins, 1'b0);
    total++; if (a_rs1 !== 5'd2 || a_rs2 !== 5'd27) begin bad++; $display("FAIL dec_rs_addi got=%0d/%0d exp=2/27", a_rs1, a_rs2); end
    tick();
    total++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd1 || a_ex_aluop !== 4'd0) begin bad++; $display("FAIL dec_addi_fields got=v%0h rd%0d op%0h exp=v1 rd1 op0", a_ex_valid, a_ex_rd, a_ex_aluop); end
    total++; if (a_ex_imm !== 32'hFFFF_FFFB) begin bad++; $display("FAIL dec_addi_imm got=%0h exp=fffffffb", a_ex_imm); end
    total++; if (a_ex_rw !== 1'b1 || a_ex_pv !== 1'b0 || a_ex_instr !== ins) begin bad++; $display("FAIL dec_addi_ctl got=rw%0h pv%0h ins%0h exp=rw1 pv0 ins%0h", a_ex_rw, a_ex_pv, a_ex_instr, ins); end
    drive(1'b1, mk_r(5'd4, 5'd5, 5'd6, 3'd0, 1'b1), 1'b0);
    total++; if (a_rs2 !== 5'd6 || a_ready !== 1'b1) begin bad++; $display("FAIL dec_sub_rs2_ready got=%0d/%0h exp=6/1", a_rs2, a_ready); end
    tick();
    total++; if (a_ex_aluop !== 4'h8 || a_ex_rd !== 5'd4 || a_ex_imm !== 32'h0) begin bad++; $display("FAIL dec_sub got=op%0h rd%0d imm%0h exp=op8 rd4 imm0", a_ex_aluop, a_ex_rd, a_ex_imm); end
    drive(1'b1, mk_p(5'd7), 1'b0);
    tick();
    total++; if (a_ex_valid !== 1'b1 || a_ex_pv !== 1'b1 || a_ex_rw !== 1'b0 || a_ex_rd !== 5'd0) begin bad++; $display("FAIL dec_print got=v%0h pv%0h rw%0h rd%0d exp=v1 pv1 rw0 rd0", a_ex_valid, a_ex_pv, a_ex_rw, a_ex_rd); end
    drive(1'b0, mk_i(5'd9, 5'd0, 12'd0, 3'd0), 1'b0);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_valid !== 1'b0 || a_ex_pv !== 1'b0 || a_ex_instr !== 32'h0) begin bad++; $display("FAIL idle_bubble got=v%0h pv%0h ins%0h exp=0/0/0", a_ex_valid, a_ex_pv, a_ex_instr); end
  endtask

  task automatic test_raw_stall();
    logic [31:0] b;
    do_reset();
    drive(1'b1, mk_i(5'd3, 5'd0, 12'd1, 3'd0), 1'b0);
    tick();
    total++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd3) begin bad++; $display("FAIL raw_a_in_ex got=v%0h rd%0d exp=v1 rd3", a_ex_valid, a_ex_rd); end
    b = mk_i(5'd8, 5'd3, 12'd2, 3'd0);
    drive(1'b1, b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL raw_ready_low[%0d] got=%0h exp=0", i, a_ready); end
      tick();
      total++; if (a_ex_valid !== 1'b0) begin bad++; $display("FAIL raw_bubble[%0d] got=%0h exp=0", i, a_ex_valid); end
    end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL raw_ready_release got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_valid !== 1'b1 || a_ex_instr !== b) begin bad++; $display("FAIL raw_b_in_ex got=v%0h ins%0h exp=v1 ins%0h", a_ex_valid, a_ex_instr, b); end
    total++; if (a_cnt !== 16'd3) begin bad++; $display("FAIL raw_cnt got=%0d exp=3", a_cnt); end
    // producer two ahead: one stall fewer per cycle of separation
    drive(1'b1, mk_i(5'd9, 5'd0, 12'd0, 3'd0), 1'b0);
    tick();
    drive(1'b1, mk_i(5'd10, 5'd0, 12'd0, 3'd0), 1'b0);
    tick();
    drive(1'b1, mk_i(5'd11, 5'd9, 12'd0, 3'd0), 1'b0);
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL dist2_stall0 got=%0h exp=0", a_ready); end
    tick();
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL dist2_stall_wb got=%0h exp=0", a_ready); end
    tick();
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL dist2_release got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_rd !== 5'd11 || a_cnt !== 16'd5) begin bad++; $display("FAIL dist2_issue got=rd%0d cnt%0d exp=rd11 cnt5", a_ex_rd, a_cnt); end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(1'b1, mk_i(5'd0, 5'd0, 12'd5, 3'd0), 1'b0);
    tick();
    drive(1'b1, mk_i(5'd8, 5'd3, 12'd2, 3'd0), 1'b0);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd8) begin bad++; $display("FAIL x0_b_next got=v%0h rd%0d exp=v1 rd8", a_ex_valid, a_ex_rd); end
    drive(1'b1, mk_s(5'd0, 5'd0, 12'h003), 1'b0);
    tick();
    total++; if (a_ex_rw !== 1'b0 || a_ex_imm !== 32'd3 || a_ex_rd !== 5'd0) begin bad++; $display("FAIL store_dec got=rw%0h imm%0h rd%0d exp=rw0 imm3 rd0", a_ex_rw, a_ex_imm, a_ex_rd); end
    drive(1'b1, mk_i(5'd8, 5'd3, 12'd2, 3'd0), 1'b0);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL norw_ready got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_valid !== 1'b1 || a_cnt !== 16'd0) begin bad++; $display("FAIL norw_issue got=v%0h cnt%0d exp=v1 cnt0", a_ex_valid, a_cnt); end
  endtask

  task automatic test_forward();
    do_reset();
    drive(1'b1, mk_i(5'd5, 5'd0, 12'd0, 3'd0), 1'b0);
    tick();
    total++; if (f_sel1 !== 2'd0 || f_sel2 !== 2'd0) begin bad++; $display("FAIL fwd_a_sel got=%0d/%0d exp=0/0", f_sel1, f_sel2); end
    drive(1'b1, mk_i(5'd6, 5'd0, 12'd0, 3'd0), 1'b0);
    tick();
    drive(1'b1, mk_r(5'd11, 5'd5, 5'd6, 3'd0, 1'b0), 1'b0);
    total++; if (f_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%0h exp=1", f_ready); end
    tick();
    total++; if (f_ex_valid !== 1'b1 || f_sel1 !== 2'd2 || f_sel2 !== 2'd1) begin bad++; $display("FAIL fwd_b_sel got=v%0h %0d/%0d exp=v1 2/1", f_ex_valid, f_sel1, f_sel2); end
    drive(1'b1, mk_r(5'd12, 5'd5, 5'd0, 3'd0, 1'b0), 1'b0);
    tick();
    total++; if (f_sel1 !== 2'd3 || f_sel2 !== 2'd0 || f_cnt !== 16'd0) begin bad++; $display("FAIL fwd_wb_sel got=%0d/%0d cnt%0d exp=3/0 cnt0", f_sel1, f_sel2, f_cnt); end
  endtask

  task automatic test_flush();
    logic [31:0] b;
    do_reset();
    b = mk_i(5'd8, 5'd3, 12'd2, 3'd0);
    drive(1'b1, mk_i(5'd3, 5'd0, 12'd1, 3'd0), 1'b0);
    tick();
    drive(1'b1, b, 1'b0);
    tick();
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL flush_pre_cnt got=%0d exp=1", a_cnt); end
    drive(1'b1, b, 1'b1);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_valid !== 1'b0 || a_cnt !== 16'd1) begin bad++; $display("FAIL flush_bubble got=v%0h cnt%0d exp=v0 cnt1", a_ex_valid, a_cnt); end
    drive(1'b1, mk_i(5'd12, 5'd3, 12'd0, 3'd0), 1'b0);
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL flush_sb_wb got=%0h exp=0", a_ready); end
    tick();
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL flush_sb_gone got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_rd !== 5'd12 || a_cnt !== 16'd2) begin bad++; $display("FAIL flush_after got=rd%0d cnt%0d exp=rd12 cnt2", a_ex_rd, a_cnt); end
  endtask

  // continues from test_flush: x12 producer sits in EX, counter at 2
  task automatic test_reset_mid_stall();
    drive(1'b1, mk_i(5'd13, 5'd12, 12'd0, 3'd0), 1'b0);
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_pre_stall got=%0h exp=0", a_ready); end
    reset_n = 1'b0;
    #1;
    total++; if (a_ex_valid !== 1'b0 || a_ex_rd !== 5'd0 || a_ex_instr !== 32'h0) begin bad++; $display("FAIL rst_mid_ex got=v%0h rd%0d ins%0h exp=0/0/0", a_ex_valid, a_ex_rd, a_ex_instr); end
    total++; if (a_cnt !== 16'd0 || a_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_cnt_ready got=%0d/%0h exp=0/1", a_cnt, a_ready); end
    tick();
    reset_n = 1'b1;
    drive(1'b1, mk_i(5'd13, 5'd12, 12'd0, 3'd0), 1'b0);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_sb_empty got=%0h exp=1", a_ready); end
    tick();
    total++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd13) begin bad++; $display("FAIL rst_mid_issue got=v%0h rd%0d exp=v1 rd13", a_ex_valid, a_ex_rd); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1'b1, mk_i(5'd3, 5'd0, 12'd1, 3'd0), 1'b0);
    tick();
    drive(1'b1, mk_i(5'd8, 5'd3, 12'd2, 3'd0), 1'b0);
    tick();
    total++; if (s_cnt !== 2'd1) begin bad++; $display("FAIL sat_first got=%0d exp=1", s_cnt); end
    tick();
    tick();
    total++; if (s_cnt !== 2'd3) begin bad++; $display("FAIL sat_reach got=%0d exp=3", s_cnt); end
    tick();
    drive(1'b1, mk_i(5'd9, 5'd8, 12'd0, 3'd0), 1'b0);
    for (int i = 0; i < 3; i++) tick();
    total++; if (s_cnt !== 2'd3 || a_cnt !== 16'd6) begin bad++; $display("FAIL sat_hold got=%0d wide%0d exp=3 wide6", s_cnt, a_cnt); end
    tick();
    total++; if (s_ex_valid !== 1'b1 || s_ex_rd !== 5'd9) begin bad++; $display("FAIL sat_issue got=v%0h rd%0d exp=v1 rd9", s_ex_valid, s_ex_rd); end
  endtask

  initial begin
    reset_n    = 1'b1;
    r_id_valid = 1'b0;
    r_id_instr = 32'h0;
    i_flush    = 1'b0;
    #2;
    test_reset();
    test_decode();
    test_raw_stall();
    test_no_stall();
    test_forward();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
